// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants and types for the inverse key schedule
package aes_pkg;

  localparam int NR = 10;

  // Index 0 is unused; the round counter addresses entries 1..NR directly.
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    SERVE
  } state_t;

  typedef logic [0:127] block_t;

endpackage

// File: rtl/inv_key_sched_if.sv
// rtl/inv_key_sched_if.sv - key-in / round-key-out handshake bundle
interface inv_key_sched_if;
  import aes_pkg::*;

  logic       key_valid;
  logic       key_ready;
  block_t     cipher_key;
  logic       rk_valid;
  logic       rk_req;
  block_t     rk_out;
  logic [3:0] rk_idx;
  logic       done;

  modport master (
    output key_valid, cipher_key, rk_req,
    input  key_ready, rk_valid, rk_out, rk_idx, done
  );

  modport slave (
    input  key_valid, cipher_key, rk_req,
    output key_ready, rk_valid, rk_out, rk_idx, done
  );

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = SBOX[{a, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_sched.sv
// rtl/inv_key_sched.sv - AES-128 key expansion served in decryption order
// Optional expanded-key cache: INV_KEY_SCHED_CACHE_EN
module inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input logic            clk,
  input logic            rst,
  inv_key_sched_if.slave bus
);

  localparam logic [3:0] LAST = 4'(NR);

  state_t     state;
  logic [3:0] r;
  block_t     rk_buf [0:NR];

  logic       key_ready_q;
  logic       rk_valid_q;
  block_t     rk_out_q;
  logic [3:0] rk_idx_q;
  logic       done_q;

  assign bus.key_ready = key_ready_q;
  assign bus.rk_valid  = rk_valid_q;
  assign bus.rk_out    = rk_out_q;
  assign bus.rk_idx    = rk_idx_q;
  assign bus.done      = done_q;

  logic accept;
  logic hit;

  assign accept = (state == IDLE) && bus.key_valid && key_ready_q;

`ifdef INV_KEY_SCHED_CACHE_EN
  logic   cache_valid;
  block_t cache_key;

  assign hit = cache_valid && (bus.cipher_key == cache_key);

  // A miss overwrites entry 0 at once, so the cache is invalid until the new expansion completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
    end else if (accept && !hit) begin
      cache_valid <= 1'b0;
    end else if (state == EXPAND && r == LAST) begin
      cache_valid <= 1'b1;
      cache_key   <= rk_buf[0];
    end
  end
`else
  assign hit = 1'b0;
`endif

  logic [3:0]  src;
  block_t      prev;
  block_t      next;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    src  = (r == 4'd0) ? 4'd0 : r - 4'd1;
    prev = rk_buf[src];
  end

  assign w0  = prev[0:31];
  assign w1  = prev[32:63];
  assign w2  = prev[64:95];
  assign w3  = prev[96:127];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot[8*i +: 8]),
      .s (sub[8*i +: 8])
    );
  end

  assign t    = sub ^ {RCON[r], 24'h000000};
  assign n0   = w0 ^ t;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign next = {n0, n1, n2, n3};

  logic       wr_en;
  logic [3:0] wr_idx;
  block_t     wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = r;
    wr_data = next;
    if (accept && !hit) begin
      wr_en   = 1'b1;
      wr_idx  = 4'd0;
      wr_data = bus.cipher_key;
    end else if (state == EXPAND) begin
      wr_en = 1'b1;
    end
  end

  // The schedule buffer has no reset; it is only visible through rk_out_q while rk_valid is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      rk_buf[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      r           <= 4'd0;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      rk_out_q    <= '0;
      rk_idx_q    <= 4'd0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            key_ready_q <= 1'b0;
            if (hit) begin
              state      <= SERVE;
              rk_valid_q <= 1'b1;
              rk_idx_q   <= LAST;
              rk_out_q   <= rk_buf[NR];
            end else begin
              state <= EXPAND;
              r     <= 4'd1;
            end
          end
        end
        EXPAND: begin
          if (r == LAST) begin
            state      <= SERVE;
            r          <= 4'd0;
            rk_valid_q <= 1'b1;
            rk_idx_q   <= LAST;
            rk_out_q   <= next;
          end else begin
            r <= r + 4'd1;
          end
        end
        SERVE: begin
          if (bus.rk_req) begin
            if (rk_idx_q == 4'd0) begin
              state       <= IDLE;
              rk_valid_q  <= 1'b0;
              rk_out_q    <= '0;
              done_q      <= 1'b1;
              key_ready_q <= 1'b1;
            end else begin
              rk_idx_q <= rk_idx_q - 4'd1;
              rk_out_q <= rk_buf[rk_idx_q - 4'd1];
            end
          end
        end
        default: begin
          state       <= IDLE;
          key_ready_q <= 1'b1;
          rk_valid_q  <= 1'b0;
          rk_out_q    <= '0;
          rk_idx_q    <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_sched.sv
// tb/tb_inv_key_sched.sv - randomized self-checking bench for inv_key_sched
module tb_inv_key_sched;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] ref_rk   [0:10];
  logic [127:0] obs_rk   [0:10];

`ifdef INV_KEY_SCHED_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 11;
`endif

  inv_key_sched_if bus ();

  inv_key_sched #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 11; k++) ref_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic exp_ready);
    chk({tag, "_valid"}, 128'(bus.rk_valid), 128'(0));
    chk({tag, "_out"}, bus.rk_out, 128'(0));
    chk({tag, "_idx"}, 128'(bus.rk_idx), 128'(0));
    chk({tag, "_ready"}, 128'(bus.key_ready), 128'(exp_ready));
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called just after a clock edge; presents key for one cycle and returns one cycle after acceptance.
  task automatic accept_key(input logic [127:0] key);
    bus.key_valid  = 1'b1;
    bus.cipher_key = key;
    chk("accept_ready", 128'(bus.key_ready), 128'(1));
    @(posedge clk); #1;
    bus.key_valid  = 1'b0;
    bus.cipher_key = rand_key();
  endtask

  task automatic run_key(input logic [127:0] key, input int lat, input bit rand_req, input bit poke);
    int cyc = 1;
    int e   = 10;
    int n   = 0;
    bit req;
    model_expand(key);
    accept_key(key);
    while (!bus.rk_valid && cyc < 20) begin
      chk_idle_outputs("wait", 1'b0);
      chk("wait_done", 128'(bus.done), 128'(0));
      bus.rk_req    = 1'($urandom_range(0, 1));
      bus.key_valid = poke && (cyc == 3);
      bus.cipher_key = rand_key();
      @(posedge clk); #1;
      cyc++;
    end
    bus.key_valid = 1'b0;
    chk("latency", 128'(cyc), 128'(lat));
    while (e >= 0 && n < 200) begin
      chk("srv_valid", 128'(bus.rk_valid), 128'(1));
      chk("srv_idx", 128'(bus.rk_idx), 128'(e));
      chk("srv_out", bus.rk_out, ref_rk[e]);
      chk("srv_done", 128'(bus.done), 128'(0));
      chk("srv_ready", 128'(bus.key_ready), 128'(0));
      obs_rk[e] = bus.rk_out;
      req = rand_req ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rk_req     = req;
      bus.key_valid  = poke && (e == 7);
      bus.cipher_key = rand_key();
      @(posedge clk); #1;
      n++;
      if (req) e--;
    end
    bus.rk_req    = 1'b0;
    bus.key_valid = 1'b0;
    chk("srv_complete", 128'(e < 0), 128'(1));
    chk("done_pulse", 128'(bus.done), 128'(1));
    chk_idle_outputs("after", 1'b1);
    @(posedge clk); #1;
    chk("done_clear", 128'(bus.done), 128'(0));
  endtask

  initial begin
    logic [127:0] k;
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.key_valid  = 1'b0;
    bus.cipher_key = '0;
    bus.rk_req     = 1'b0;
    build_sbox();

    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset", 1'b1);
    chk("reset_done", 128'(bus.done), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_key(128'h000102030405060708090a0b0c0d0e0f, 11, 1'b0, 1'b0);
    chk("kat0_rk10", obs_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("kat0_rk0", obs_rk[0], 128'h000102030405060708090a0b0c0d0e0f);

    // Back-to-back: next key presented in the cycle after done.
    run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 11, 1'b1, 1'b0);
    chk("kat1_rk10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("kat1_rk1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

    for (int i = 0; i < 3; i++) run_key(rand_key(), 11, 1'b1, 1'b1);

    k = rand_key();
    accept_key(k);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle_outputs("midrst", 1'b1);
    run_key(k, 11, 1'b1, 1'b0);

    k = rand_key();
    run_key(k, 11, 1'b0, 1'b0);
    run_key(k, HIT_LAT, 1'b1, 1'b1);
    run_key(rand_key(), 11, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_key_sched.md
INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 SHALL have parameter NR, default 10, the number of cipher rounds; 10 (AES-128) is the only legal value.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port key_valid  input  1  cipher_key is presented.
REQ-005 SHALL have port key_ready  output  1  block accepts a new cipher key.
REQ-006 SHALL have port cipher_key  input  128 ([0:127])  AES-128 cipher key, byte 0 at bits [0:7].
REQ-007 SHALL have port rk_valid  output  1  rk_out holds a valid round key.
REQ-008 SHALL have port rk_req  input  1  the downstream inverse round consumes rk_out this cycle.
REQ-009 SHALL have port rk_out  output  128 ([0:127])  round key, served in decryption order.
REQ-010 SHALL have port rk_idx  output  4  round number of rk_out, from NR down to 0.
REQ-011 SHALL have port done  output  1  one-cycle pulse after round key 0 is consumed.

Function
REQ-012 SHALL implement the FSM states IDLE, EXPAND and SERVE.
REQ-013 IDLE: key_ready=1; a key is accepted when key_valid and key_ready are both high in the same cycle.
REQ-014 On acceptance (cycle T), SHALL store cipher_key as buffer entry 0 and enter EXPAND with the round counter r=1.
REQ-015 EXPAND: SHALL compute one round key per cycle, entry r = FIPS-197 expansion of entry r-1 with Rcon[r] (RotWord, SubWord, Rcon XOR, then the word chain); r=NR is computed in cycle T+NR.
REQ-016 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36 in the most significant byte.
REQ-017 After entry NR is written, SHALL enter SERVE with rk_idx=NR; the first rk_valid=1 occurs at cycle T+NR+1 (T+11).
REQ-018 SERVE: rk_valid=1 and rk_out=buffer[rk_idx]; rk_out SHALL be driven only from registers (no combinational path from inputs).
REQ-019 rk_valid and rk_req both high SHALL decrement rk_idx in the next cycle; rk_req=0 SHALL hold rk_idx and rk_out stable for any number of cycles.
REQ-020 Consumption at rk_idx=0 SHALL return the FSM to IDLE, pulse done for the next cycle, and drop rk_valid in that same cycle.
REQ-021 key_ready=0 in EXPAND and SERVE; key_valid in those states SHALL be ignored and SHALL NOT corrupt the buffer.
REQ-022 rk_req outside SERVE SHALL be ignored.
REQ-023 When rk_valid=0, rk_out SHALL be all-zero and rk_idx SHALL be 0.
REQ-024 A new key SHALL be acceptable in the cycle after done (back-to-back keys).

Reset
REQ-025 rst SHALL force IDLE, key_ready=1 on the following cycle, rk_valid=0, rk_out=0, rk_idx=0, done=0, and r=0, from any state including mid-EXPAND or mid-SERVE.
REQ-026 Buffer contents are not cleared by reset; they SHALL never be observable while rk_valid=0.

Configuration
REQ-027 Macro INV_KEY_SCHED_CACHE_EN: when defined, SHALL keep a cache-valid flag (cleared by rst) and a copy of the last expanded key.
REQ-028 With INV_KEY_SCHED_CACHE_EN: an accepted key equal to the cached key while the cache is valid SHALL skip EXPAND and enter SERVE directly, giving rk_valid=1 at T+1; an accepted key that differs SHALL expand normally and update the cache.
REQ-029 Without INV_KEY_SCHED_CACHE_EN: every accepted key SHALL expand (REQ-014..017), and no cache register SHALL exist.

Structure
REQ-030 Shared package aes_pkg SHALL hold NR, the Rcon table, the FSM state typedef and a 128-bit block typedef.
REQ-031 SHALL instantiate sub-module aes_sbox (byte in, byte out, combinational) four times for SubWord.
REQ-032 The buffer SHALL be NR+1 registers of 128 bits, indexed by round.

Verification
REQ-033 Key 000102030405060708090a0b0c0d0e0f at T, rk_req=1 constantly -> rk_valid at T+11 with rk_idx=10 and rk_out=13111d7fe3944a17f307a78b4d2b30c5; the last key out is 000102...0f with rk_idx=0; done pulses once.
REQ-034 Key 2b7e151628aed2a6abf7158809cf4f3c -> rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=1 gives a0fafe1788542cb123a339392a6c7605.
REQ-035 rk_req toggled at random in SERVE -> each of the 11 keys is delivered exactly once, in order, and held stable while rk_req=0.
REQ-036 rst asserted in EXPAND at T+5, then the same key reapplied -> correct full schedule, no stale values, and rk_valid stays 0 until T'+11.
REQ-037 key_valid pulsed during EXPAND and SERVE -> ignored; the schedule matches the original key.
REQ-038 INV_KEY_SCHED_CACHE_EN defined, same key sent twice -> the second rk_valid appears at T+1 with identical keys; a different key takes 11 cycles.
